printf_port_arbiter: RTL
========================

Name: printf_port_arbiter

Overview:
- Shares the single printf debug channel between NREQ on-chip requesters (rF0 core, management-side firmware mailbox, etc.).
- The channel is an 8-bit data bus (routed to mprj_io[15:8]) plus a strobe (routed to the gpio pad). The testbench samples the byte on the strobe rising edge and ends the test on byte 0x04.
- The block arbitrates round-robin, accepts one byte at a time and sequences the setup/strobe/hold timing so the byte is stable around the strobe edge.

Parameters:
- NREQ, 2, number of requesters (1..8)
- SETUP_CYC, 2, cycles io_data is stable before io_strobe rises (>=1)
- STROBE_CYC, 4, cycles io_strobe stays high (>=1)
- HOLD_CYC, 2, cycles io_data is held after io_strobe falls (>=1)

Ports:
- wb_clk_i  input  1  clock
- wb_rst_i  input  1  reset, asynchronous, active-high
- req_valid  input  NREQ  requester i has a byte
- req_data  input  8*NREQ  byte of requester i in bits [8i+7:8i]
- req_ready  output  NREQ  one-hot grant; byte transfers on valid&ready at the clock edge
- io_data  output  8  printf byte to the pads
- io_strobe  output  1  printf strobe to the gpio pad
- busy  output  1  high in any state other than IDLE
- grant_id  output  3  index of the requester that owns the current or last byte
- eot  output  1  sticky; set when byte 0x04 has been emitted

Behaviour:
- Reset is applied immediately, with no clock. State=IDLE, io_data=0, io_strobe=0, req_ready=0, busy=0, grant_id=0, eot=0, RR pointer=NREQ-1 (so requester 0 has highest priority first).
- Reset mid-byte aborts the byte: io_strobe drops at once and the byte is lost.
- States:
  - IDLE
  - SETUP
  - STROBE
  - HOLD
  - DONE (only with the optional feature)
- IDLE:
  - req_ready is combinational: a one-hot grant to the first valid requester at or after (pointer+1) mod NREQ, searched in wrapping order.
  - With no valid requester, req_ready=0.
  - On a transfer: latch the byte into io_data, set grant_id, set pointer to the granted index, load the counter with SETUP_CYC, go to SETUP.
- SETUP: io_strobe=0. Count down; at expiry load STROBE_CYC and go to STROBE.
- STROBE: io_strobe=1 (registered). Count down; at expiry load HOLD_CYC and go to HOLD.
- HOLD: io_strobe=0, io_data held. Count down; at expiry go to IDLE.
- req_ready=0 in every state except IDLE.
- Timing, with the transfer edge as cycle 0:
  - io_data is valid from cycle 1.
  - io_strobe is high for cycles SETUP_CYC+1 through SETUP_CYC+STROBE_CYC.
  - The next transfer is possible at the edge ending cycle SETUP_CYC+STROBE_CYC+HOLD_CYC+1.
  - Byte period is 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles (9 at defaults).
- io_data keeps the last byte in IDLE and is never changed while io_strobe=1.
- eot is set on the cycle io_strobe rises for byte 0x04.
- Requesters must hold req_valid and req_data stable until they are granted. Dropping valid before the grant is legal; the byte is simply not taken.
- Simultaneous valids are resolved by the RR order only. No requester waits more than NREQ-1 bytes.
- The counter is wide enough for max(SETUP_CYC, STROBE_CYC, HOLD_CYC).

Optional Feature:
- Macro: PRINTF_EOT_LOCK_EN
- Defined: after HOLD of a 0x04 byte, the FSM enters DONE instead of IDLE. In DONE, req_ready=0 permanently, busy=1, and io_data=0x04 is held. Only wb_rst_i exits DONE.
- Undefined: the DONE state does not exist. 0x04 sets eot but is otherwise an ordinary byte, and arbitration continues.

Test Plan:
- Reset, then requester 0 sends 0x41 alone -> req_ready[0] high in the IDLE cycle; io_data=0x41 from cycle 1; io_strobe high in cycles 3–6; busy low again at cycle 9; grant_id=0.
- Both requesters hold valid continuously, streaming 0x30.. and 0x61.. -> strobed bytes alternate 0x30,0x61,0x31,0x62; first grant goes to 0; each strobe rising edge is 9 cycles apart.
- Monitor on every io_strobe rising edge and throughout strobe-high -> io_data unchanged from the cycle before the rise until the cycle after the fall; no glitches on io_strobe.
- Assert wb_rst_i asynchronously in the 2nd STROBE cycle -> io_strobe=0 and req_ready=0 before the next clock edge; after release, requester 0 wins first.
- Requester 1 sends 0x04 -> eot=1 on the strobe rise. With PRINTF_EOT_LOCK_EN: a subsequent 0x55 from requester 0 is never granted, and busy stays 1. Without the macro: 0x55 is emitted 9 cycles later.
- NREQ=1 build with a continuous stream of 0x00..0x0F -> all 16 bytes emitted in order, one per 9 cycles.

Source files
------------

// File: rtl/printf_port_arbiter.sv
// Round-robin arbiter sharing the printf byte/strobe debug channel.
// Optional PRINTF_EOT_LOCK_EN: lock in DONE after emitting byte 0x04.
module printf_port_arbiter #(
  parameter int NREQ       = 2,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        io_data,
  output logic              io_strobe,
  output logic              busy,
  output logic [2:0]        grant_id,
  output logic              eot
);

  localparam int MAXC =
    (SETUP_CYC > STROBE_CYC)
      ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
      : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
`ifdef PRINTF_EOT_LOCK_EN
    , S_DONE
`endif
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [2:0]      r_ptr;
  logic [7:0]      r_data;
  logic            r_strobe;
  logic [2:0]      r_gid;
  logic            r_eot;
  logic [NREQ-1:0] w_gnt_oh;
  logic [2:0]      w_gnt_idx;
  logic            w_gnt_vld;
  logic            w_xfer;
  logic            w_expire;
  logic [7:0]      w_byte;
  int              w_idx;

  // Search starts one past the last winner and wraps.
  always_comb begin
    w_gnt_oh  = '0;
    w_gnt_idx = '0;
    w_gnt_vld = 1'b0;
    w_idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NREQ;
      if (!w_gnt_vld && req_valid[w_idx]) begin
        w_gnt_vld       = 1'b1;
        w_gnt_oh[w_idx] = 1'b1;
        w_gnt_idx       = 3'(w_idx);
      end
    end
  end

  assign w_byte   = req_data[8*int'(w_gnt_idx) +: 8];
  assign w_xfer   = |req_ready;
  assign w_expire = (r_cnt == CW'(1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_next    = S_SETUP;
          w_cnt_nxt = CW'(SETUP_CYC);
        end
      end
      S_SETUP: begin
        if (w_expire) begin
          w_next    = S_STROBE;
          w_cnt_nxt = CW'(STROBE_CYC);
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_STROBE: begin
        if (w_expire) begin
          w_next    = S_HOLD;
          w_cnt_nxt = CW'(HOLD_CYC);
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_HOLD: begin
        if (w_expire) begin
`ifdef PRINTF_EOT_LOCK_EN
          w_next = (r_data == 8'h04) ? S_DONE : S_IDLE;
`else
          w_next = S_IDLE;
`endif
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
`ifdef PRINTF_EOT_LOCK_EN
      S_DONE: w_next = S_DONE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = (r_state != S_IDLE);
    if (r_state == S_IDLE && !wb_rst_i) req_ready = w_gnt_oh;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ptr    <= 3'(NREQ - 1);
      r_data   <= '0;
      r_strobe <= 1'b0;
      r_gid    <= '0;
      r_eot    <= 1'b0;
    end else begin
      r_strobe <= (w_next == S_STROBE);
      if (r_state == S_SETUP && w_next == S_STROBE && r_data == 8'h04)
        r_eot <= 1'b1;
      if (w_xfer) begin
        r_data <= w_byte;
        r_gid  <= w_gnt_idx;
        r_ptr  <= w_gnt_idx;
      end
    end
  end

  assign io_data   = r_data;
  assign io_strobe = r_strobe;
  assign grant_id  = r_gid;
  assign eot       = r_eot;

endmodule
